// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program-counter sequencer with writable branch-target table
module pc_sequencer #(
    parameter int             D        = 12,
    parameter logic [D-1:0]   START_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         branch_en,
    input  logic [2:0]   how_high,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [D-1:0] cfg_data,
    input  logic         cfg_abs,
    output logic [D-1:0] pc,
    output logic         fetch_valid,
    output logic         busy,
    output logic         done,
    output logic [15:0]  icount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [D-1:0] DEF_MINUS5 = ~D'(4);
    localparam logic [D-1:0] DEF_PLUS20 = D'(20);
    localparam logic [D-1:0] DEF_MINUS1 = '1;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [15:0]   icount_q, icount_d;
    logic [D-1:0]  tgt_q [8];
    logic [D-1:0]  tgt_d [8];
    logic [7:0]    abs_q, abs_d;

    logic [D-1:0]  entry_tgt;
    logic          entry_abs;
    logic [15:0]   icount_inc;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        icount_d   = icount_q;
        tgt_d      = tgt_q;
        abs_d      = abs_q;
        // Branch lookup uses the table contents before this cycle's write.
        entry_tgt  = tgt_q[how_high];
        entry_abs  = abs_q[how_high];
        icount_inc = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d  = ST_RUN;
                    pc_d     = START_PC;
                    icount_d = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end else if (branch_en) begin
                        pc_d     = entry_abs ? entry_tgt : pc_q + entry_tgt;
                        icount_d = icount_inc;
                    end else begin
                        pc_d     = pc_q + D'(1);
                        icount_d = icount_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cfg_we) begin
            tgt_d[cfg_addr] = cfg_data;
            abs_d[cfg_addr] = cfg_abs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            icount_q <= '0;
            abs_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                tgt_q[i] <= '0;
            end
            tgt_q[0] <= DEF_MINUS5;
            tgt_q[1] <= DEF_PLUS20;
            tgt_q[2] <= DEF_MINUS1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
            tgt_q    <= tgt_d;
            abs_q    <= abs_d;
        end
    end

    assign pc          = pc_q;
    assign icount      = icount_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_HALTED);
    assign fetch_valid = busy & ~stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer with behavioural model and per-cycle compare
module tb_pc_sequencer;

    localparam int D    = 12;
    localparam int MODV = 4096;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start, stall, halt_req, branch_en, cfg_we, cfg_abs;
    logic [2:0]   how_high, cfg_addr;
    logic [D-1:0] cfg_data;
    logic [D-1:0] pc;
    logic         fetch_valid, busy, done;
    logic [15:0]  icount;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.D(D), .START_PC('0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .branch_en   (branch_en),
        .how_high    (how_high),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_abs     (cfg_abs),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .busy        (busy),
        .done        (done),
        .icount      (icount)
    );

    always #5 clk = ~clk;

    // Behavioural model: running/halted flags, integer PC and count, table as int arrays.
    bit m_run, m_halt;
    int m_pc, m_cnt;
    int m_tgt [8];
    bit m_abs [8];
    int sel_tgt;
    bit sel_abs;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run  = 0;
            m_halt = 0;
            m_pc   = 0;
            m_cnt  = 0;
            for (int i = 0; i < 8; i++) begin
                m_tgt[i] = 0;
                m_abs[i] = 0;
            end
            m_tgt[0] = MODV - 5;
            m_tgt[1] = 20;
            m_tgt[2] = MODV - 1;
        end else begin
            sel_tgt = m_tgt[how_high];
            sel_abs = m_abs[how_high];
            if (!m_run) begin
                if (start) begin
                    m_run  = 1;
                    m_halt = 0;
                    m_pc   = 0;
                    m_cnt  = 0;
                end
            end else if (!stall) begin
                if (halt_req) begin
                    m_run  = 0;
                    m_halt = 1;
                end else begin
                    if (branch_en) m_pc = sel_abs ? sel_tgt : (m_pc + sel_tgt) % MODV;
                    else           m_pc = (m_pc + 1) % MODV;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end
            if (cfg_we) begin
                m_tgt[cfg_addr] = int'(cfg_data);
                m_abs[cfg_addr] = cfg_abs;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_pc",          int'(pc),          m_pc);
            chk("model_icount",      int'(icount),      m_cnt);
            chk("model_busy",        int'(busy),        int'(m_run));
            chk("model_done",        int'(done),        int'(m_halt));
            chk("model_fetch_valid", int'(fetch_valid), int'(m_run && !stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        start = 0; stall = 0; halt_req = 0; branch_en = 0; how_high = 0;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_abs = 0;
    endtask

    task automatic branch(input logic [2:0] idx);
        idle_in();
        branch_en = 1; how_high = idx;
        tick();
    endtask

    initial begin
        idle_in();
        #1 reset_n = 0;
        #1;
        chk("rst_pc",     int'(pc), 0);
        chk("rst_icount", int'(icount), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_fv",     int'(fetch_valid), 0);
        chk_on = 1;
        repeat (2) @(posedge clk);
        #2 reset_n = 1;

        start = 1; tick(); start = 0;
        chk("start_pc", int'(pc), 0);
        chk("start_busy", int'(busy), 1);
        tick(); tick();
        start = 1; tick(); start = 0;
        tick();
        chk("run4_pc", int'(pc), 4);
        chk("run4_icount", int'(icount), 4);

        branch(3'd0);
        chk("br_m5_pc", int'(pc), 12'hFFF);
        idle_in(); tick();
        chk("wrap_pc", int'(pc), 0);
        repeat (4) tick();
        branch(3'd1);
        chk("br_p20_pc", int'(pc), 12'h018);
        chk("br_p20_icount", int'(icount), 11);

        idle_in(); halt_req = 1; tick(); idle_in();
        chk("halt1_done", int'(done), 1);
        start = 1; tick(); start = 0;
        repeat (7) tick();
        chk("pre_rbw_pc", int'(pc), 7);

        idle_in();
        cfg_we = 1; cfg_addr = 3; cfg_data = 12'h100; cfg_abs = 1;
        branch_en = 1; how_high = 3;
        tick();
        chk("rbw_old_pc", int'(pc), 7);
        branch(3'd3);
        chk("rbw_new_pc", int'(pc), 12'h100);

        idle_in();
        cfg_we = 1; cfg_addr = 4; cfg_data = 12'h010; cfg_abs = 1;
        tick();
        branch(3'd4);
        chk("abs4_pc", int'(pc), 12'h010);

        idle_in();
        stall = 1; branch_en = 1; halt_req = 1; how_high = 2;
        cfg_we = 1; cfg_addr = 5; cfg_data = 12'h020; cfg_abs = 1;
        #1 chk("stall_fv", int'(fetch_valid), 0);
        tick();
        cfg_we = 0;
        tick();
        chk("stall_pc", int'(pc), 12'h010);
        chk("stall_icount", int'(icount), 11);
        branch(3'd2);
        chk("br_m1_pc", int'(pc), 12'h00F);

        branch(3'd5);
        chk("abs5_pc", int'(pc), 12'h020);
        idle_in(); halt_req = 1; tick(); idle_in();
        tick();
        chk("halt2_done", int'(done), 1);
        chk("halt2_busy", int'(busy), 0);
        chk("halt2_pc", int'(pc), 12'h020);

        start = 1; tick(); start = 0;
        chk("restart_pc", int'(pc), 0);
        chk("restart_icount", int'(icount), 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_done", int'(done), 0);
        tick(); tick();

        reset_n = 0;
        #1;
        chk("midrst_pc", int'(pc), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        tick();
        reset_n = 1;
        start = 1; tick(); start = 0;
        branch(3'd3);
        chk("tbl_dflt_pc", int'(pc), 0);
        chk("tbl_dflt_icount", int'(icount), 1);

        idle_in();
        tick();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
